// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types and constants for the instruction loader
package inst_loader_pkg;

    // Number of byte lanes in one instruction word and derived widths.
    localparam int NUM_LANES  = 4;
    localparam int LANE_IDX_W = $clog2(NUM_LANES);
    localparam int WORD_W     = 8 * NUM_LANES;

    // Loader FSM state encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FULL    = 2'd3
    } state_e;

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - instruction memory write bus
interface inst_loader_if
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) ();

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_din;

    // The loader drives the bus; the instruction memory consumes it.
    modport master (output mem_we, mem_addr, mem_din);
    modport slave  (input  mem_we, mem_addr, mem_din);

endinterface

// File: rtl/inst_loader_key_pulse.sv
// rtl/inst_loader_key_pulse.sv - push-button debouncer with single-clock press pulse
module key_pulse
    import inst_loader_pkg::*;
#(
    parameter int DEBOUNCE_N = 19
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic pulse
);

    localparam logic [DEBOUNCE_N-1:0] TICK_ONE = {{(DEBOUNCE_N-1){1'b0}}, 1'b1};

    logic [DEBOUNCE_N-1:0] tick_cnt_q, tick_cnt_d;
    logic                  tick;
    logic [1:0]            sync_q;
    logic                  stable_q, stable_d;
    logic [1:0]            run_q, run_d;
    logic                  stable_prev_q;

    // The tick fires once every 2^DEBOUNCE_N clocks, on the counter's last value.
    assign tick       = (tick_cnt_q == {DEBOUNCE_N{1'b1}});
    assign tick_cnt_d = tick_cnt_q + TICK_ONE;

    // Two-flop synchroniser: the raw button is asynchronous to clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], key};
        end
    end

    // Count consecutive ticks that disagree with the stable level; three flip it,
    // any agreeing sample starts the count over.
    always_comb begin
        stable_d = stable_q;
        run_d    = run_q;
        if (tick) begin
            if (sync_q[1] != stable_q) begin
                if (run_q == 2'd2) begin
                    stable_d = sync_q[1];
                    run_d    = 2'd0;
                end else begin
                    run_d = run_q + 2'd1;
                end
            end else begin
                run_d = 2'd0;
            end
        end
    end

    // Tick counter, debounce state and previous stable level for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_q    <= '0;
            stable_q      <= 1'b0;
            run_q         <= 2'd0;
            stable_prev_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            stable_q      <= stable_d;
            run_q         <= run_d;
            stable_prev_q <= stable_q;
        end
    end

    // One clock high on the debounced rising edge only; a held key stays silent.
    assign pulse = stable_q & ~stable_prev_q;

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-at-a-time instruction memory loader driven by a push-button
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEBOUNCE_N = 19,
    parameter int ADDR_W     = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic                  key,
    input  logic [7:0]            sw,
    inst_loader_if.master         mem,
    output logic [LANE_IDX_W-1:0] byte_idx,
    output logic                  full,
    output logic [7:0]            LED
);

    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(NUM_LANES - 1);
    localparam logic [ADDR_W-1:0]     LAST_ADDR = {ADDR_W{1'b1}};

    state_e                  state_q, state_d;
    logic [LANE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic [7:0]              led_q, led_d;
    logic                    pulse;

    key_pulse #(
        .DEBOUNCE_N(DEBOUNCE_N)
    ) u_key_pulse (
        .clock(clock),
        .reset(reset),
        .key  (key),
        .pulse(pulse)
    );

    // Next-state logic: dropping load_en overrides everything and clears the
    // partial word; a WRITE in this cycle has already strobed mem_we.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        word_d     = word_q;
        led_d      = led_q;
        if (!load_en) begin
            state_d    = IDLE;
            byte_idx_d = '0;
            addr_d     = '0;
            word_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = COLLECT;
                    byte_idx_d = '0;
                end
                COLLECT: begin
                    if (pulse) begin
                        word_d[{byte_idx_q, 3'b000} +: 8] = sw;
                        led_d                             = sw;
                        byte_idx_d                        = byte_idx_q + LANE_IDX_W'(1);
                        if (byte_idx_q == LAST_LANE) begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Pulses landing here are dropped, never queued.
                    byte_idx_d = '0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = FULL;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = COLLECT;
                    end
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any word or write in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            led_q      <= led_d;
        end
    end

    // Outputs decode straight from registers so reset clears them immediately.
    assign mem.mem_we   = (state_q == WRITE);
    assign mem.mem_addr = addr_q;
    assign mem.mem_din  = word_q;
    assign full         = (state_q == FULL);
    assign byte_idx     = byte_idx_q;
    assign LED          = led_q;

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_N, default 19, meaning the tick period is 2^DEBOUNCE_N clocks (about 10 ms at board clock).
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the word-address width (64-word instruction memory).
REQ-003 SHALL have port clock, input, 1, system clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port load_en, input, 1, level switch: 1 = loading mode, 0 = abort/idle.
REQ-006 SHALL have port key, input, 1, raw bouncy push-button, active-high.
REQ-007 SHALL have port sw, input, 8, data byte to enter.
REQ-008 SHALL have port mem_we, output, 1, memory write strobe.
REQ-009 SHALL have port mem_addr, output, ADDR_W, word address.
REQ-010 SHALL have port mem_din, output, 32, word to write.
REQ-011 SHALL have port byte_idx, output, 2, next byte lane to be filled.
REQ-012 SHALL have port full, output, 1, high once the last address has been written.
REQ-013 SHALL have port LED, output, 8, echo of the most recently latched byte.

Function
REQ-014 SHALL debounce key as follows: key is accepted as pressed after high for 3 consecutive ticks, and released after low for 3 consecutive ticks; any contrary sample returns the debouncer to the prior stable state.
REQ-015 SHALL generate a press pulse, exactly 1 clock wide, on the debounced rising edge only; a held key yields one pulse.
REQ-016 SHALL implement FSM states IDLE, COLLECT, WRITE, FULL.
REQ-017 SHALL, in IDLE, move to COLLECT on the first clock with load_en=1, with byte_idx=0.
REQ-018 SHALL, in COLLECT, on a pulse latch sw into word lane byte_idx (0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]), copy sw to LED, and increment byte_idx.
REQ-019 SHALL, on the pulse that fills lane 3, enter WRITE the next clock.
REQ-020 SHALL, in WRITE, hold mem_we=1 for exactly 1 clock with mem_din equal to the assembled word and mem_addr equal to the current address.
REQ-021 SHALL, after WRITE, reset byte_idx to 0; if the address was 2^ADDR_W-1 go to FULL, else increment the address and return to COLLECT.
REQ-022 SHALL, in FULL, assert full=1, ignore pulses, and keep mem_we=0; leave FULL only when load_en=0 (to IDLE).
REQ-023 SHALL ignore a pulse coinciding with WRITE; it is not latched and not queued.
REQ-024 SHALL, when load_en=0 in any state, go to IDLE the next clock, discard the partial word, clear byte_idx and full, and set the address to 0; a WRITE in progress that cycle still completes.
REQ-025 SHALL keep mem_we=0 in all states except WRITE.
REQ-026 SHALL not wrap the address silently; there is no write beyond the last address.

Reset
REQ-027 SHALL, on reset, immediately set state=IDLE, mem_we=0, mem_addr=0, mem_din=0, byte_idx=0, full=0, LED=0, and clear the debouncer and tick counter.
REQ-028 SHALL, on reset asserted mid-word or mid-WRITE, abort the write with no strobe after release.

Structure
REQ-029 SHALL place the FSM state encoding and the byte-lane count (4) in the shared package.
REQ-030 SHALL implement debounce plus edge detection as sub-module key_pulse (parameter DEBOUNCE_N; ports clock, reset, key, pulse), reusable by other board-input blocks.

Verification
REQ-031 SHALL run benches with DEBOUNCE_N=2 (tick every 4 clocks).
REQ-032 SHALL cover: clean presses with sw=0x13,0x00,0x00,0x20 → one mem_we at addr 0, mem_din=0x20000013; then byte_idx=0, addr=1.
REQ-033 SHALL cover: key bouncing 1-0-1 within 2 ticks, then stable for 3 ticks → exactly one pulse, byte_idx advances by 1.
REQ-034 SHALL cover: 256 byte entries with ADDR_W=6 → 64 writes (addr 0..63), full=1; a further press gives no mem_we; load_en=0 → IDLE, full=0.
REQ-035 SHALL cover: 2 bytes entered, then load_en dropped and raised → byte_idx=0, addr=0, next word assembled from fresh bytes only.
REQ-036 SHALL cover: reset asserted in the WRITE cycle → mem_we=0 immediately, all outputs at reset values, no write after release.
